pixel_serializer: RTL and testbench
===================================

PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 Parameter IN_ROWS, default 20, frame height in pixels.
REQ-002 Parameter IN_COLS, default 20, frame width in pixels; SHALL be a multiple of PIXELS_PER_BURST.
REQ-003 Parameter PIXELS_PER_BURST, default 4, Mono8 pixels packed per input word.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ap_start  input  1  start one frame; sampled only in IDLE.
REQ-007 ap_ready  output  1  high in IDLE.
REQ-008 ap_idle  output  1  high in IDLE.
REQ-009 ap_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-010 s_axis_tvalid / s_axis_tready  input / output  1 / 1  burst handshake.
REQ-011 s_axis_tdata  input  8*PIXELS_PER_BURST  packed pixels; byte 0 (LSBs) is leftmost.
REQ-012 s_axis_tlast  input  1  upstream marker for the final burst of a frame.
REQ-013 m_axis_tvalid / m_axis_tready  output / input  1 / 1  pixel handshake.
REQ-014 m_axis_tdata  output  8  current pixel.
REQ-015 cnt_col  output  $clog2(IN_COLS)  column of the current m_axis pixel.
REQ-016 cnt_row  output  $clog2(IN_ROWS)  row of the current m_axis pixel.
REQ-017 err_tlast  output  1  sticky tlast-mismatch flag.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN on ap_start.
- RUN -> DONE when pixel (IN_ROWS-1, IN_COLS-1) is accepted.
- DONE -> IDLE after exactly one cycle.
REQ-019 In RUN, a burst register and a pixel index (0..PIXELS_PER_BURST-1) SHALL hold one burst; m_axis_tvalid = buffer full.
REQ-020 s_axis_tready SHALL be high in RUN when the buffer is empty, or when the last pixel of the buffer is being accepted, provided the frame's final burst is not already loaded. Back-to-back bursts SHALL then stream at 1 pixel/cycle with no bubble.
REQ-021 s_axis_tready SHALL be 0 in IDLE and DONE; bursts beyond the frame are never accepted.
REQ-022 m_axis_tdata SHALL equal byte [index] of the burst register; latency from burst acceptance to first pixel valid is 1 cycle.
REQ-023 m_axis_tdata, cnt_col and cnt_row SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 On each pixel handshake:
- cnt_col increments.
- At IN_COLS-1, cnt_col wraps to 0 and cnt_row increments.
- Both counters reset to 0 on IDLE->RUN.
REQ-025 ap_done SHALL pulse in DONE only; ap_start in RUN or DONE SHALL be ignored.
REQ-026 Simultaneous final-pixel acceptance and new burst offer: the burst SHALL NOT be accepted.

Reset
REQ-027 While reset=1, state SHALL be IDLE, the buffer empty, and the counters, index and err_tlast 0.
REQ-028 Reset output values: ap_idle=1, ap_ready=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0.
REQ-029 Reset mid-frame SHALL discard the buffered burst with no ap_done; the next frame SHALL start at (0,0).

Configuration
REQ-030 With PIXEL_SERIALIZER_TLAST_CHECK_EN defined, err_tlast SHALL set on accepting a burst whose s_axis_tlast disagrees with "this is burst IN_ROWS*IN_COLS/PIXELS_PER_BURST - 1". It clears only on reset; the frame continues unaffected.
REQ-031 Without PIXEL_SERIALIZER_TLAST_CHECK_EN, err_tlast SHALL be tied 0 and s_axis_tlast ignored.

Verification (IN_ROWS=4, IN_COLS=8, PIXELS_PER_BURST=4: 8 bursts, 32 pixels)
REQ-032 Reset, then ap_start, then 8 bursts with bytes 0..31, m_axis_tready=1 -> 32 pixels 0..31 on consecutive cycles; (row,col) runs (0,0)..(3,7); single ap_done pulse; ap_idle=1 after.
REQ-033 Same stimulus with m_axis_tready toggling 1/0 -> identical pixel order; outputs stable during stalls; s_axis_tready never high with the buffer holding unsent pixels (except on the last-pixel accept).
REQ-034 s_axis_tvalid=1 with 9 bursts offered -> only 8 accepted; s_axis_tready=0 in DONE and IDLE.
REQ-035 Reset asserted after 13 pixels, then a new frame -> no ap_done for the aborted frame; the new frame starts at (0,0) with the new data.
REQ-036 Macro defined, tlast on burst 5 -> err_tlast=1 from the cycle after burst 5 is accepted and stays set; without the macro -> err_tlast stays 0.
REQ-037 ap_start held high in RUN -> the frame is unaffected; the next frame starts only after returning to IDLE.

Source files
------------

// File: rtl/pixel_serializer.sv
// pixel_serializer: unpacks PIXELS_PER_BURST Mono8 pixels per input burst into a one-pixel stream.
// Define PIXEL_SERIALIZER_TLAST_CHECK_EN to enable the sticky s_axis_tlast mismatch flag (err_tlast).
module pixel_serializer #(
    parameter int unsigned IN_ROWS          = 20,
    parameter int unsigned IN_COLS          = 20,
    parameter int unsigned PIXELS_PER_BURST = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ap_start,
    output logic                            ap_ready,
    output logic                            ap_idle,
    output logic                            ap_done,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [8*PIXELS_PER_BURST-1:0]   s_axis_tdata,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [7:0]                      m_axis_tdata,
    output logic [$clog2(IN_COLS)-1:0]      cnt_col,
    output logic [$clog2(IN_ROWS)-1:0]      cnt_row,
    output logic                            err_tlast
);

    localparam int unsigned CW = $clog2(IN_COLS);
    localparam int unsigned RW = $clog2(IN_ROWS);
    localparam int unsigned IW = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
    localparam int unsigned NB = IN_ROWS * IN_COLS / PIXELS_PER_BURST;
    localparam int unsigned BW = $clog2(NB + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                          r_state;
    logic [8*PIXELS_PER_BURST-1:0]   r_buf;
    logic                            r_full;
    logic [IW-1:0]                   r_idx;
    logic [CW-1:0]                   r_col;
    logic [RW-1:0]                   r_row;
    logic [BW-1:0]                   r_bcnt;
    logic                            r_last_loaded;

    logic                            w_pix_acc;
    logic                            w_idx_last;
    logic                            w_col_last;
    logic                            w_frame_end;
    logic                            w_final_burst;
    logic                            w_burst_acc;
    logic [7:0]                      w_bytes [PIXELS_PER_BURST];

    for (genvar g = 0; g < PIXELS_PER_BURST; g++) begin : g_bytes
        assign w_bytes[g] = r_buf[8*g +: 8];
    end

    assign w_pix_acc     = r_full && m_axis_tready;
    assign w_idx_last    = (r_idx == IW'(PIXELS_PER_BURST - 1));
    assign w_col_last    = (r_col == CW'(IN_COLS - 1));
    assign w_frame_end   = w_pix_acc && w_col_last && (r_row == RW'(IN_ROWS - 1));
    assign w_final_burst = (r_bcnt == BW'(NB - 1));

    // Refill when empty or as the last buffered pixel leaves, unless the frame's final burst is already in.
    assign s_axis_tready = (r_state == S_RUN) && !r_last_loaded &&
                           (!r_full || (w_pix_acc && w_idx_last));
    assign w_burst_acc   = s_axis_tvalid && s_axis_tready;

    assign ap_idle       = (r_state == S_IDLE);
    assign ap_ready      = (r_state == S_IDLE);
    assign ap_done       = (r_state == S_DONE);
    assign m_axis_tvalid = r_full;
    assign m_axis_tdata  = w_bytes[r_idx];
    assign cnt_col       = r_col;
    assign cnt_row       = r_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_buf         <= '0;
            r_full        <= 1'b0;
            r_idx         <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_bcnt        <= '0;
            r_last_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_state       <= S_RUN;
                        r_full        <= 1'b0;
                        r_idx         <= '0;
                        r_col         <= '0;
                        r_row         <= '0;
                        r_bcnt        <= '0;
                        r_last_loaded <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_pix_acc) begin
                        if (w_idx_last) begin
                            r_idx  <= '0;
                            r_full <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= w_frame_end ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                    // A new burst overrides the empty-buffer update above.
                    if (w_burst_acc) begin
                        r_buf         <= s_axis_tdata;
                        r_full        <= 1'b1;
                        r_idx         <= '0;
                        r_bcnt        <= r_bcnt + BW'(1);
                        r_last_loaded <= w_final_burst;
                    end
                    if (w_frame_end) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PIXEL_SERIALIZER_TLAST_CHECK_EN
    logic r_err;

    // Sticky flag: tlast must be set on exactly the frame's final burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_burst_acc && (s_axis_tlast != w_final_burst)) begin
            r_err <= 1'b1;
        end
    end

    assign err_tlast = r_err;
`else
    logic w_unused_tlast;

    assign w_unused_tlast = s_axis_tlast;
    assign err_tlast      = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// Self-checking bench for pixel_serializer (4 rows x 8 cols, 4 pixels per burst).
// Honours PIXEL_SERIALIZER_TLAST_CHECK_EN when predicting err_tlast.
module tb_pixel_serializer;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int PPB  = 4;
    localparam int NB   = ROWS * COLS / PPB;
    localparam int NPIX = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic [2:0]  cnt_col;
    logic [1:0]  cnt_row;
    logic        err_tlast;

    int checks   = 0;
    int failures = 0;
    bit m_err    = 1'b0;

    always #5 clk = ~clk;

    pixel_serializer #(
        .IN_ROWS          (ROWS),
        .IN_COLS          (COLS),
        .PIXELS_PER_BURST (PPB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_idle       (ap_idle),
        .ap_done       (ap_done),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .cnt_col       (cnt_col),
        .cnt_row       (cnt_row),
        .err_tlast     (err_tlast)
    );

    typedef struct {
        bit          start;
        bit          sv;
        logic [31:0] sd;
        bit          mr;
        bit          idle;
        bit          sr;
        bit          mv;
        logic [7:0]  md;
        int          col;
        int          row;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] burst(input int base, input int k);
        logic [31:0] b;
        for (int j = 0; j < PPB; j++) b[8*j +: 8] = 8'(base + PPB*k + j);
        return b;
    endfunction

    // Drives one frame while a small model predicts every handshake output cycle by cycle.
    task automatic run_frame(input int base, input bit toggle, input bit flood, input bit hold,
                             input int tlast_b, input int abort_at);
        int st, bacc, pcnt;
        bit exp_mv, exp_sr, acc_b, acc_p, finished;
        st = 0; bacc = 0; pcnt = 0; finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (st == 1 && pcnt == abort_at) begin
                reset = 1'b1; ap_start = 1'b0; s_axis_tvalid = 1'b0;
                #1;
                chk("abort_idle",   int'(ap_idle), 1);
                chk("abort_done",   int'(ap_done), 0);
                chk("abort_mvalid", int'(m_axis_tvalid), 0);
                chk("abort_sready", int'(s_axis_tready), 0);
                chk("abort_col",    int'(cnt_col), 0);
                chk("abort_row",    int'(cnt_row), 0);
                chk("abort_err",    int'(err_tlast), 0);
                m_err = 1'b0;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            ap_start      = (cyc == 0) || (hold && st != 0);
            m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
            s_axis_tvalid = flood || (st == 1 && bacc < NB);
            s_axis_tdata  = burst(base, bacc);
            s_axis_tlast  = (bacc == tlast_b);
            #1;
            exp_mv = (st == 1) && (bacc * PPB > pcnt);
            exp_sr = (st == 1) && (bacc < NB) &&
                     ((bacc * PPB == pcnt) ||
                      (m_axis_tready && (pcnt % PPB == PPB - 1) && (bacc * PPB == pcnt + 1)));
            chk("ap_idle",  int'(ap_idle), int'(st == 0));
            chk("ap_ready", int'(ap_ready), int'(st == 0));
            chk("ap_done",  int'(ap_done), int'(st == 2));
            chk("m_valid",  int'(m_axis_tvalid), int'(exp_mv));
            chk("s_ready",  int'(s_axis_tready), int'(exp_sr));
            chk("err_tlast", int'(err_tlast), int'(m_err));
            if (exp_mv) begin
                chk("m_data", int'(m_axis_tdata), (base + pcnt) % 256);
                chk("cnt_col", int'(cnt_col), pcnt % COLS);
                chk("cnt_row", int'(cnt_row), pcnt / COLS);
            end
            acc_b = s_axis_tvalid && exp_sr;
            acc_p = exp_mv && m_axis_tready;
            @(posedge clk);
            case (st)
                0: if (cyc == 0) st = 1; else finished = 1'b1;
                1: begin
                    if (acc_b) begin
`ifdef PIXEL_SERIALIZER_TLAST_CHECK_EN
                        if (s_axis_tlast != (bacc == NB - 1)) m_err = 1'b1;
`endif
                        bacc++;
                    end
                    if (acc_p) pcnt++;
                    if (pcnt == NPIX) st = 2;
                end
                default: st = 0;
            endcase
        end
        if (!finished) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [15];
        vt[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0};
        vt[1]  = '{1'b0, 1'b1, 32'h03020100, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
        vt[2]  = '{1'b0, 1'b1, 32'h07060504, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0};
        vt[3]  = '{1'b0, 1'b1, 32'h07060504, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1, 0};
        vt[4]  = '{1'b0, 1'b1, 32'h07060504, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 2, 0};
        vt[5]  = '{1'b0, 1'b1, 32'h07060504, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 3, 0};
        vt[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 4, 0};
        vt[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 4, 0};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 4, 0};
        vt[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 5, 0};
        vt[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h06, 6, 0};
        vt[11] = '{1'b0, 1'b1, 32'h0b0a0908, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 7, 0};
        vt[12] = '{1'b0, 1'b1, 32'h0b0a0908, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 7, 0};
        vt[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 0, 1};
        vt[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 1, 1};

        reset = 1'b1; ap_start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_idle",   int'(ap_idle), 1);
        chk("rst_ready",  int'(ap_ready), 1);
        chk("rst_done",   int'(ap_done), 0);
        chk("rst_sready", int'(s_axis_tready), 0);
        chk("rst_mvalid", int'(m_axis_tvalid), 0);
        chk("rst_mdata",  int'(m_axis_tdata), 0);
        chk("rst_col",    int'(cnt_col), 0);
        chk("rst_row",    int'(cnt_row), 0);
        chk("rst_err",    int'(err_tlast), 0);
        reset = 1'b0;

        // Cycle-exact start, back-to-back refill, stalls (incl. on the last buffered pixel) and column wrap.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ap_start = vt[i].start; s_axis_tvalid = vt[i].sv; s_axis_tdata = vt[i].sd;
            m_axis_tready = vt[i].mr; s_axis_tlast = 1'b0;
            #1;
            chk($sformatf("vec%0d_idle", i),   int'(ap_idle), int'(vt[i].idle));
            chk($sformatf("vec%0d_sready", i), int'(s_axis_tready), int'(vt[i].sr));
            chk($sformatf("vec%0d_mvalid", i), int'(m_axis_tvalid), int'(vt[i].mv));
            chk($sformatf("vec%0d_mdata", i),  int'(m_axis_tdata), int'(vt[i].md));
            chk($sformatf("vec%0d_col", i),    int'(cnt_col), vt[i].col);
            chk($sformatf("vec%0d_row", i),    int'(cnt_row), vt[i].row);
            chk($sformatf("vec%0d_done", i),   int'(ap_done), 0);
        end

        // Abort the table frame with a reset; no ap_done may follow.
        @(negedge clk);
        reset = 1'b1; ap_start = 1'b0; s_axis_tvalid = 1'b0;
        #1;
        chk("mid_rst_mvalid", int'(m_axis_tvalid), 0);
        chk("mid_rst_idle",   int'(ap_idle), 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done",   int'(ap_done), 0);
            chk("post_rst_idle",   int'(ap_idle), 1);
            chk("post_rst_sready", int'(s_axis_tready), 0);
        end

        run_frame(0,   1'b0, 1'b0, 1'b0, NB - 1, -1);   // full-rate frame, pixels 0..31
        run_frame(0,   1'b1, 1'b0, 1'b0, NB - 1, -1);   // m_axis_tready toggling
        run_frame(64,  1'b0, 1'b1, 1'b0, NB - 1, -1);   // s_axis_tvalid held high beyond the frame
        run_frame(0,   1'b0, 1'b0, 1'b0, NB - 1, 13);   // reset after 13 pixels
        run_frame(100, 1'b0, 1'b0, 1'b0, NB - 1, -1);   // fresh frame after the abort
        run_frame(160, 1'b1, 1'b0, 1'b0, 5,      -1);   // tlast on burst 5
        run_frame(200, 1'b0, 1'b0, 1'b1, NB - 1, -1);   // ap_start held through RUN and DONE

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
